multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) and divide (restoring) beside the ALU.
// Optional MULTDIV_EARLY_OUT_EN: zero-operand multiply and zero-divisor divide finish after one iteration cycle.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             is_div;
    logic             neg;
    logic             dz;
`ifdef MULTDIV_EARLY_OUT_EN
    logic             skip;
`endif

    logic             req_c;
    logic             iter_c;
    logic             done_c;
    logic             last_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH:0]   acc_x_c;
    logic [WIDTH:0]   mcand_x_c;
    logic [WIDTH:0]   sum_x_c;
    logic [PW-1:0]    prod_step_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] rem_step_c;
    logic [WIDTH-1:0] quo_step_c;
    logic [WIDTH-1:0] quo_signed_c;
    logic             mult_ovf_c;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a new request in any state aborts and restarts, multiply winning ties
    always_comb begin
        state_nxt = state;
        iter_c    = 1'b0;
        done_c    = 1'b0;
        req_c     = ctrl_MULT | ctrl_DIV;
        last_c    = (count == CW'(WIDTH - 1));
        case (state)
            IDLE: state_nxt = IDLE;
            MULT, DIV: begin
                iter_c = 1'b1;
                if (last_c) begin
                    state_nxt = DONE;
                end
`ifdef MULTDIV_EARLY_OUT_EN
                if (skip) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (req_c) begin
            state_nxt = ctrl_MULT ? MULT : DIV;
            iter_c    = 1'b0;
            done_c    = 1'b0;
        end
    end

    // Operand magnitudes; the most-negative value maps to itself as an unsigned quantity
    always_comb begin
        mag_a_c = data_operandA[WIDTH-1] ? (WIDTH'(0) - data_operandA) : data_operandA;
        mag_b_c = data_operandB[WIDTH-1] ? (WIDTH'(0) - data_operandB) : data_operandB;
    end

    // Booth step; the add is one bit wider so a most-negative multiplicand cannot overflow
    always_comb begin
        acc_x_c   = {prod[PW-1], prod[PW-1:WIDTH+1]};
        mcand_x_c = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   sum_x_c = acc_x_c + mcand_x_c;
            2'b10:   sum_x_c = acc_x_c - mcand_x_c;
            default: sum_x_c = acc_x_c;
        endcase
        prod_step_c = {sum_x_c, prod[WIDTH:1]};
        mult_ovf_c  = ~((&prod[PW-1:WIDTH]) | ~(|prod[PW-1:WIDTH]));
    end

    // Restoring divide step: one quotient bit per cycle shifted into quo
    always_comb begin
        shifted_c = {rem, quo[WIDTH-1]};
        trial_c   = shifted_c - {1'b0, dvsr};
        if (!trial_c[WIDTH]) begin
            rem_step_c = trial_c[WIDTH-1:0];
            quo_step_c = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_c = shifted_c[WIDTH-1:0];
            quo_step_c = {quo[WIDTH-2:0], 1'b0};
        end
        quo_signed_c = neg ? (WIDTH'(0) - quo) : quo;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count          <= '0;
            prod           <= '0;
            mcand          <= '0;
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            is_div         <= 1'b0;
            neg            <= 1'b0;
            dz             <= 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
            skip           <= 1'b0;
`endif
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (req_c) begin
            count          <= '0;
            prod           <= {WIDTH'(0), data_operandB, 1'b0};
            mcand          <= data_operandA;
            rem            <= '0;
            quo            <= mag_a_c;
            dvsr           <= mag_b_c;
            is_div         <= ~ctrl_MULT;
            neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz             <= (data_operandB == '0);
`ifdef MULTDIV_EARLY_OUT_EN
            skip           <= ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                        : (data_operandB == '0);
`endif
            data_resultRDY <= 1'b0;
        end else if (iter_c) begin
            count          <= count + CW'(1);
            data_resultRDY <= 1'b0;
            if (is_div) begin
                rem <= rem_step_c;
                quo <= quo_step_c;
            end else begin
                prod <= prod_step_c;
            end
        end else if (done_c) begin
            data_resultRDY <= 1'b1;
            if (is_div) begin
                if (dz) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= quo_signed_c;
                    data_exception <= ~neg & quo[WIDTH-1];
                end
            end else
`ifdef MULTDIV_EARLY_OUT_EN
            if (skip) begin
                data_result    <= '0;
                data_exception <= 1'b0;
            end else
`endif
            begin
                data_result    <= prod[WIDTH:1];
                data_exception <= mult_ovf_c;
            end
        end else begin
            data_resultRDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed + random scoreboard bench for multdiv_unit.
module tb_multdiv_unit;

    localparam int unsigned W = 32;
    localparam int FULL_LAT = W + 1;
`ifdef MULTDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = W + 1;
`endif

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         exc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] res, input logic exc, input int lat);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.exc = exc;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Expected result from plain 64-bit signed arithmetic
    task automatic push_model(input string tag, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       p;
        logic [63:0]  pv;
        if (m) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pv = p;
            push(tag, pv[31:0], !((&pv[63:31]) || !(|pv[63:31])),
                 ((a == '0) || (b == '0)) ? EARLY_LAT : FULL_LAT);
        end else if (b == '0) begin
            push(tag, '0, 1'b1, EARLY_LAT);
        end else begin
            p  = longint'($signed(a)) / longint'($signed(b));
            pv = p;
            push(tag, pv[31:0], (p > 64'sd2147483647), FULL_LAT);
        end
    endtask

    // Request lands on the next rising edge (edge 0); operands scrambled afterwards
    task automatic issue(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 100);
        check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
        check({e.tag, "_res"}, 64'(data_result), 64'(e.res));
        check({e.tag, "_exc"}, 64'(data_exception), 64'(e.exc));
        @(posedge clock);
        #1;
        check({e.tag, "_rdy_low"}, 64'(data_resultRDY), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           cnt;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (2) @(posedge clock);
        #1;
        check("reset_res", 64'(data_result), 64'(0));
        check("reset_exc", 64'(data_exception), 64'(0));
        check("reset_rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        push("mul_7x-3", 32'hFFFF_FFEB, 1'b0, FULL_LAT);
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_rdy();

        push("mul_ovf", 32'h0000_0000, 1'b1, FULL_LAT);
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_rdy();

        push("mul_minneg", 32'h8000_0000, 1'b1, FULL_LAT);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy();

        push("mul_zero", 32'h0000_0000, 1'b0, EARLY_LAT);
        issue(1'b1, 1'b0, 32'd0, 32'h0001_2345);
        wait_rdy();

        push("div_-7/2", 32'hFFFF_FFFD, 1'b0, FULL_LAT);
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_rdy();

        push("div_7/-2", 32'hFFFF_FFFD, 1'b0, FULL_LAT);
        issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_rdy();

        push("div_by0", 32'h0000_0000, 1'b1, EARLY_LAT);
        issue(1'b0, 1'b1, 32'd100, 32'd0);
        wait_rdy();

        push("div_ovf", 32'h8000_0000, 1'b1, FULL_LAT);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy();

        push("div_minneg/1", 32'h8000_0000, 1'b0, FULL_LAT);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'd1);
        wait_rdy();

        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            push_model("mul_rand", 1'b1, a, b);
            issue(1'b1, 1'b0, a, b);
            wait_rdy();
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            push_model("div_rand", 1'b0, a, b);
            issue(1'b0, 1'b1, a, b);
            wait_rdy();
        end

        // Abort: multiply restarted as a divide at edge 10
        cnt = 0;
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
        push("abort_div", 32'd10, 1'b0, FULL_LAT);
        issue(1'b0, 1'b1, 32'd50, 32'd5);
        wait_rdy();
        check("abort_no_rdy", 64'(cnt), 64'(0));

        push("both_high", 32'd8, 1'b0, FULL_LAT);
        issue(1'b1, 1'b1, 32'd4, 32'd2);
        wait_rdy();

        // Async reset at edge 20 of a multiply
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (19) @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_res", 64'(data_result), 64'(0));
        check("rst_mid_exc", 64'(data_exception), 64'(0));
        check("rst_mid_rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
        check("rst_no_rdy", 64'(cnt), 64'(0));
        check("rst_res_hold", 64'(data_result), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
